// File: rtl/elevator_status_display_if.sv
// Bus between the elevator controller and the status display: car status in, segment/anode drive and divided clocks out.
interface elevator_status_display_if;
  logic [1:0] piso;
  logic [1:0] accion;
  logic       puertas;
  logic [7:0] DISPLAY;
  logic [3:0] ANODES;
  logic       CLK_1KHz;
  logic       CLK_2Hz;
  logic       CLK_1Hz;

  modport master (
    output piso, accion, puertas,
    input  DISPLAY, ANODES, CLK_1KHz, CLK_2Hz, CLK_1Hz
  );

  modport slave (
    input  piso, accion, puertas,
    output DISPLAY, ANODES, CLK_1KHz, CLK_2Hz, CLK_1Hz
  );
endinterface

// File: rtl/elevator_status_display.sv
// Four-digit multiplexed 7-segment status display for an elevator car plus 1 kHz / 2 Hz / 1 Hz dividers.
// Optional macro DOOR_BLINK_EN: the open-door 'A' blinks with CLK_2Hz instead of showing steadily.
module elevator_status_display #(
  parameter int unsigned CLK_HZ = 100000000
) (
  input  logic                      clk,
  input  logic                      rst,
  elevator_status_display_if.slave  bus
);

  localparam int unsigned HALF1K = CLK_HZ / 2000;
  localparam int unsigned HALF2H = CLK_HZ / 4;
  localparam int unsigned HALF1H = CLK_HZ / 2;

  localparam int unsigned W1K = $clog2(HALF1K);
  localparam int unsigned W2H = $clog2(HALF2H);
  localparam int unsigned W1H = $clog2(HALF1H);

  localparam logic [W1K-1:0] LAST1K = W1K'(HALF1K - 1);
  localparam logic [W2H-1:0] LAST2H = W2H'(HALF2H - 1);
  localparam logic [W1H-1:0] LAST1H = W1H'(HALF1H - 1);

  // Symbol codes 1..4 are the floor digits themselves, so piso+1 needs no mapping.
  localparam logic [3:0] SYM_S     = 4'h5;
  localparam logic [3:0] SYM_A     = 4'hA;
  localparam logic [3:0] SYM_B     = 4'hB;
  localparam logic [3:0] SYM_C     = 4'hC;
  localparam logic [3:0] SYM_P     = 4'hD;
  localparam logic [3:0] SYM_DASH  = 4'hE;
  localparam logic [3:0] SYM_BLANK = 4'hF;

  localparam logic [7:0] SEG_1     = 8'b10011111;
  localparam logic [7:0] SEG_2     = 8'b00100101;
  localparam logic [7:0] SEG_3     = 8'b00001101;
  localparam logic [7:0] SEG_4     = 8'b10011001;
  localparam logic [7:0] SEG_S     = 8'b01001001;
  localparam logic [7:0] SEG_B     = 8'b11000001;
  localparam logic [7:0] SEG_A     = 8'b00010001;
  localparam logic [7:0] SEG_C     = 8'b01100011;
  localparam logic [7:0] SEG_P     = 8'b00110001;
  localparam logic [7:0] SEG_DASH  = 8'b11111101;
  localparam logic [7:0] SEG_BLANK = 8'b11111111;

  function automatic logic [7:0] decodeSym(input logic [3:0] sym);
    logic [7:0] seg;
    case (sym)
      4'h1:     seg = SEG_1;
      4'h2:     seg = SEG_2;
      4'h3:     seg = SEG_3;
      4'h4:     seg = SEG_4;
      SYM_S:    seg = SEG_S;
      SYM_B:    seg = SEG_B;
      SYM_A:    seg = SEG_A;
      SYM_C:    seg = SEG_C;
      SYM_P:    seg = SEG_P;
      SYM_DASH: seg = SEG_DASH;
      default:  seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  logic [W1K-1:0] cnt1k_q, cnt1k_d;
  logic [W2H-1:0] cnt2h_q, cnt2h_d;
  logic [W1H-1:0] cnt1h_q, cnt1h_d;
  logic           clk1k_q, clk1k_d;
  logic           clk2h_q, clk2h_d;
  logic           clk1h_q, clk1h_d;
  logic           clk1kPrev_q;

  logic [1:0]     scanIdx_q, scanIdx_d;
  logic           scanRise;

  logic [3:0]     sym_q [4];
  logic [3:0]     sym_d [4];
  logic [7:0]     pat_q [4];
  logic [7:0]     pat_d [4];

  logic [3:0]     anodes_q, anodes_d;
  logic [7:0]     display_q, display_d;

  // Three free-running half-period counters; each output flips as its counter wraps.
  always_comb begin
    cnt1k_d = cnt1k_q + 1'b1;
    clk1k_d = clk1k_q;
    if (cnt1k_q == LAST1K) begin
      cnt1k_d = '0;
      clk1k_d = ~clk1k_q;
    end

    cnt2h_d = cnt2h_q + 1'b1;
    clk2h_d = clk2h_q;
    if (cnt2h_q == LAST2H) begin
      cnt2h_d = '0;
      clk2h_d = ~clk2h_q;
    end

    cnt1h_d = cnt1h_q + 1'b1;
    clk1h_d = clk1h_q;
    if (cnt1h_q == LAST1H) begin
      cnt1h_d = '0;
      clk1h_d = ~clk1h_q;
    end
  end

  assign scanRise  = clk1k_q & ~clk1kPrev_q;
  assign scanIdx_d = scanRise ? scanIdx_q + 2'd1 : scanIdx_q;

  always_comb begin
    sym_d[0] = {2'b00, bus.piso} + 4'd1;
    sym_d[1] = SYM_P;
`ifdef DOOR_BLINK_EN
    sym_d[2] = bus.puertas ? (clk2h_q ? SYM_A : SYM_BLANK) : SYM_C;
`else
    sym_d[2] = bus.puertas ? SYM_A : SYM_C;
`endif
    case (bus.accion)
      2'd1:    sym_d[3] = SYM_S;
      2'd2:    sym_d[3] = SYM_B;
      default: sym_d[3] = SYM_DASH;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pat_d[i] = decodeSym(sym_q[i]);
    end
    anodes_d  = ~(4'b0001 << scanIdx_q);
    display_d = pat_q[scanIdx_q];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt1k_q     <= '0;
      cnt2h_q     <= '0;
      cnt1h_q     <= '0;
      clk1k_q     <= 1'b0;
      clk2h_q     <= 1'b0;
      clk1h_q     <= 1'b0;
      clk1kPrev_q <= 1'b0;
      scanIdx_q   <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        sym_q[i] <= SYM_BLANK;
        pat_q[i] <= SEG_BLANK;
      end
      anodes_q    <= 4'b1111;
      display_q   <= SEG_BLANK;
    end else begin
      cnt1k_q     <= cnt1k_d;
      cnt2h_q     <= cnt2h_d;
      cnt1h_q     <= cnt1h_d;
      clk1k_q     <= clk1k_d;
      clk2h_q     <= clk2h_d;
      clk1h_q     <= clk1h_d;
      clk1kPrev_q <= clk1k_q;
      scanIdx_q   <= scanIdx_d;
      for (int i = 0; i < 4; i++) begin
        sym_q[i] <= sym_d[i];
        pat_q[i] <= pat_d[i];
      end
      anodes_q    <= anodes_d;
      display_q   <= display_d;
    end
  end

  assign bus.DISPLAY  = display_q;
  assign bus.ANODES   = anodes_q;
  assign bus.CLK_1KHz = clk1k_q;
  assign bus.CLK_2Hz  = clk2h_q;
  assign bus.CLK_1Hz  = clk1h_q;

endmodule

// File: tb/tb_elevator_status_display.sv
// Directed bench for elevator_status_display at CLK_HZ=8000: reset/divider timing, a table of scan vectors, mid-scan reset.
module tb_elevator_status_display;

  localparam logic [7:0] SEG_A = 8'b00010001;
  localparam logic [7:0] SEG_P = 8'b00110001;

  typedef struct {
    logic [1:0]      piso;
    logic [1:0]      accion;
    logic            puertas;
    logic [3:0][7:0] expPat;
  } vec_t;

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;
  vec_t vecs [4];

  elevator_status_display_if bus ();

  elevator_status_display #(.CLK_HZ(8000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t makeVec(input logic [1:0] p, input logic [1:0] a, input logic d,
                                   input logic [7:0] d0, input logic [7:0] d1,
                                   input logic [7:0] d2, input logic [7:0] d3);
    vec_t v;
    v.piso      = p;
    v.accion    = a;
    v.puertas   = d;
    v.expPat[0] = d0;
    v.expPat[1] = d1;
    v.expPat[2] = d2;
    v.expPat[3] = d3;
    return v;
  endfunction

  task automatic applyStimulus(input logic [1:0] p, input logic [1:0] a, input logic d);
    bus.piso    = p;
    bus.accion  = a;
    bus.puertas = d;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0b, expected %0b", name, actual, expected);
    end
  endtask

  // Samples on falling edges until the requested digit is being driven.
  task automatic waitForDigit(input int idx);
    logic [3:0] want;
    bit         found;
    want  = ~(4'b0001 << idx);
    found = 1'b0;
    for (int n = 0; n < 80 && !found; n++) begin
      @(negedge clk);
      if (bus.ANODES == want) found = 1'b1;
    end
    if (!found) checkOutput($sformatf("scan timeout digit%0d", idx), {28'd0, bus.ANODES}, {28'd0, want});
  endtask

  task automatic waitForClk2Hz(input logic level);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 5000 && !found; n++) begin
      @(negedge clk);
      if (bus.CLK_2Hz == level) found = 1'b1;
    end
    if (!found) checkOutput("CLK_2Hz timeout", {31'd0, bus.CLK_2Hz}, {31'd0, level});
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] exp2;
    assertCount = 0;
    failCount   = 0;

    vecs[0] = makeVec(2'd2, 2'd1, 1'b0, 8'b00001101, SEG_P, 8'b01100011, 8'b01001001);
    vecs[1] = makeVec(2'd3, 2'd2, 1'b1, 8'b10011001, SEG_P, SEG_A,       8'b11000001);
    vecs[2] = makeVec(2'd0, 2'd3, 1'b0, 8'b10011111, SEG_P, 8'b01100011, 8'b11111101);
    vecs[3] = makeVec(2'd1, 2'd0, 1'b1, 8'b00100101, SEG_P, SEG_A,       8'b11111101);

    rst = 1'b0;
    applyStimulus(2'd2, 2'd1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset ANODES",   {28'd0, bus.ANODES},  32'b1111);
    checkOutput("reset DISPLAY",  {24'd0, bus.DISPLAY}, 32'hFF);
    checkOutput("reset CLK_1KHz", {31'd0, bus.CLK_1KHz}, 32'd0);
    checkOutput("reset CLK_2Hz",  {31'd0, bus.CLK_2Hz},  32'd0);
    checkOutput("reset CLK_1Hz",  {31'd0, bus.CLK_1Hz},  32'd0);

    // Edge k is the k-th rising edge after release; sampled on the following falling edge.
    rst = 1'b1;
    for (int k = 1; k <= 4000; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checkOutput("edge1 ANODES",  {28'd0, bus.ANODES},  32'b1110);
        checkOutput("edge1 DISPLAY", {24'd0, bus.DISPLAY}, 32'hFF);
      end
      if (k == 2) checkOutput("edge2 DISPLAY", {24'd0, bus.DISPLAY}, 32'hFF);
      if (k == 3) begin
        checkOutput("edge3 DISPLAY",  {24'd0, bus.DISPLAY}, 32'b00001101);
        checkOutput("edge3 CLK_1KHz", {31'd0, bus.CLK_1KHz}, 32'd0);
      end
      if (k == 4)    checkOutput("edge4 CLK_1KHz",   {31'd0, bus.CLK_1KHz}, 32'd1);
      if (k == 5)    checkOutput("edge5 ANODES",     {28'd0, bus.ANODES},   32'b1110);
      if (k == 6)    checkOutput("edge6 ANODES",     {28'd0, bus.ANODES},   32'b1101);
      if (k == 7)    checkOutput("edge7 CLK_1KHz",   {31'd0, bus.CLK_1KHz}, 32'd1);
      if (k == 8)    checkOutput("edge8 CLK_1KHz",   {31'd0, bus.CLK_1KHz}, 32'd0);
      if (k == 1999) checkOutput("edge1999 CLK_2Hz", {31'd0, bus.CLK_2Hz},  32'd0);
      if (k == 2000) checkOutput("edge2000 CLK_2Hz", {31'd0, bus.CLK_2Hz},  32'd1);
      if (k == 3999) checkOutput("edge3999 CLK_1Hz", {31'd0, bus.CLK_1Hz},  32'd0);
      if (k == 4000) checkOutput("edge4000 CLK_1Hz", {31'd0, bus.CLK_1Hz},  32'd1);
    end

    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].piso, vecs[v].accion, vecs[v].puertas);
      repeat (40) @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        waitForDigit(d);
        exp2 = vecs[v].expPat[d];
`ifdef DOOR_BLINK_EN
        if (d == 2 && vecs[v].puertas) exp2 = bus.CLK_2Hz ? SEG_A : 8'hFF;
`endif
        checkOutput($sformatf("vec%0d digit%0d", v, d), {24'd0, bus.DISPLAY}, {24'd0, exp2});
      end
    end

    // Reset in the middle of a scan, while digit 2 is on.
    waitForDigit(2);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset ANODES",   {28'd0, bus.ANODES},   32'b1111);
    checkOutput("midreset DISPLAY",  {24'd0, bus.DISPLAY},  32'hFF);
    checkOutput("midreset CLK_1KHz", {31'd0, bus.CLK_1KHz}, 32'd0);
    checkOutput("midreset CLK_2Hz",  {31'd0, bus.CLK_2Hz},  32'd0);
    checkOutput("midreset CLK_1Hz",  {31'd0, bus.CLK_1Hz},  32'd0);
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) checkOutput("restart edge1 ANODES",  {28'd0, bus.ANODES},  32'b1110);
      if (k == 1) checkOutput("restart edge1 DISPLAY", {24'd0, bus.DISPLAY}, 32'hFF);
      if (k == 2) checkOutput("restart edge2 DISPLAY", {24'd0, bus.DISPLAY}, 32'hFF);
      if (k == 3) checkOutput("restart edge3 DISPLAY", {24'd0, bus.DISPLAY}, 32'b00100101);
      if (k == 5) checkOutput("restart edge5 ANODES",  {28'd0, bus.ANODES},  32'b1110);
      if (k == 6) checkOutput("restart edge6 ANODES",  {28'd0, bus.ANODES},  32'b1101);
    end

`ifdef DOOR_BLINK_EN
    applyStimulus(2'd1, 2'd0, 1'b1);
    waitForClk2Hz(1'b1);
    repeat (40) @(negedge clk);
    waitForDigit(2);
    checkOutput("blink on digit2", {24'd0, bus.DISPLAY}, {24'd0, SEG_A});
    waitForClk2Hz(1'b0);
    repeat (40) @(negedge clk);
    waitForDigit(2);
    checkOutput("blink off digit2", {24'd0, bus.DISPLAY}, 32'hFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/elevator_status_display.md
ELEVATOR_STATUS_DISPLAY -- requirements
Module: elevator_status_display

Interface
REQ-001 CLK_HZ, default 100000000, input clock frequency in Hz; SHALL be a multiple of 4000.
REQ-002 clk  input  1  sole clock; all logic SHALL use its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 piso  input  2  current floor; 0..3 = floor 1..4.
REQ-005 accion  input  2  motion; 0 idle, 1 up, 2 down, 3 treated as idle.
REQ-006 puertas  input  1  doors; 1 open, 0 closed.
REQ-007 DISPLAY  output  8  segments {a,b,c,d,e,f,g,dp}, bit7=a, active-low, registered.
REQ-008 ANODES  output  4  digit enables, active-low, bit0 = rightmost digit, registered.
REQ-009 CLK_1KHz, CLK_2Hz, CLK_1Hz  output  1 each  registered 50%-duty square waves.

Function
REQ-010 Divider: three independent counters; CLK_1KHz toggles every CLK_HZ/2000 cycles, CLK_2Hz every CLK_HZ/4, CLK_1Hz every CLK_HZ/2.
REQ-011 After reset all three divider outputs SHALL start low; the first toggle SHALL occur after one full half-period.
REQ-012 Symbol stage: every cycle four 4-bit symbol registers SHALL load from the inputs, with 1-cycle latency.
REQ-013 Symbol contents: D0 = floor digit piso+1; D1 = 'P'; D2 = 'A' if puertas=1, else 'C'.
REQ-014 Symbol contents: D3 = 'S' if accion=1, 'b' if accion=2, '-' otherwise.
REQ-015 Decode stage: patterns SHALL be registered one cycle after the symbol stage.
REQ-016 Decode table (active-low, bit7..0): 1=10011111, 2=00100101, 3=00001101, 4=10011001, S=01001001, b=11000001, A=00010001, C=01100011, P=00110001, '-'=11111101, blank=11111111.
REQ-017 Any unused symbol code SHALL decode to blank.
REQ-018 Scan index: 2-bit digit index SHALL advance by 1 (3 wraps to 0) on the clk cycle after each detected rising edge of CLK_1KHz.
REQ-019 Output stage, registered each cycle from the scan index: index 0 -> ANODES=1110, DISPLAY=D0 pattern; 1 -> 1101, D1; 2 -> 1011, D2; 3 -> 0111, D3.
REQ-020 Outside reset exactly one ANODES bit SHALL be low.
REQ-021 Latency: an input change SHALL reach DISPLAY in exactly 3 cycles while its digit is selected.
REQ-022 Inputs are synchronous to clk; no input synchronizers.

Reset
REQ-023 Values on any rising edge with rst=0: counters 0, scan index 0, CLK_* outputs 0, symbol and decode registers blank, ANODES=1111, DISPLAY=11111111.
REQ-024 Reset asserted mid-operation SHALL take effect on that same edge, regardless of divider or scan phase.
REQ-025 After reset release:
- first edge: ANODES=1110, DISPLAY=11111111.
- third edge: D0 pattern.

Configuration
REQ-026 Macro DOOR_BLINK_EN, when defined: while puertas=1, D2 SHALL be blank when CLK_2Hz=0 and 'A' when CLK_2Hz=1, with the same pipeline latency.
REQ-027 Macro DOOR_BLINK_EN, when undefined: D2 SHALL show a steady 'A' when puertas=1, and CLK_2Hz is used only as an output.

Verification
REQ-028 CLK_HZ=8000, reset released -> CLK_1KHz toggles every 4 cycles, CLK_2Hz every 2000 cycles, CLK_1Hz every 4000 cycles, all starting low.
REQ-029 piso=2, accion=1, puertas=0 -> across one scan: 1110/00001101, 1101/00110001, 1011/01100011, 0111/01001001.
REQ-030 piso=3, accion=2, puertas=1, macro undefined -> digit0=10011001, digit2=00010001, digit3=11000001.
REQ-031 piso=0, accion=3 -> digit0=10011111, digit3=11111101.
REQ-032 rst=0 while index=2 -> next edge: ANODES=1111, DISPLAY=11111111, CLK_*=0; after release, index restarts at 0 with blank for 2 cycles.
REQ-033 DOOR_BLINK_EN defined, puertas=1 -> digit2 alternates 11111111 / 00010001, following the CLK_2Hz phase.
